// File: rtl/uart_parity_unit.sv
// UART parity engine: generates the TX parity bit and checks the RX parity bit.
// Supports even/odd/mark/space parity, a runtime data length, and sticky/counted RX errors.
module uart_parity_unit #(
  parameter int MAX_WIDTH     = 9,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     parity_enable,
  input  logic [1:0]               PAR_TYP,
  input  logic [3:0]               DATA_LEN,
  input  logic [MAX_WIDTH-1:0]     P_DATA,
  input  logic                     Data_Valid,
  input  logic [MAX_WIDTH-1:0]     RX_DATA,
  input  logic                     RX_PAR_BIT,
  input  logic                     RX_Valid,
  input  logic                     ERR_CLR,
  output logic                     parity_bit,
  output logic                     par_valid,
  output logic                     par_err,
  output logic                     par_err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [4:0] MIN_LEN = 5'd5;
  localparam logic [4:0] MAX_LEN = 5'(MAX_WIDTH);

  logic [4:0]           data_len;
  logic [MAX_WIDTH-1:0] len_mask;
  logic                 tx_fire;
  logic                 rx_fire;
  logic                 tx_parity;
  logic                 rx_expected;
  logic                 rx_mismatch;

  function automatic logic parity_of(input logic [MAX_WIDTH-1:0] word,
                                     input logic [1:0]           typ);
    logic result;
    case (typ)
      2'b00:   result = ^word;
      2'b01:   result = ~^word;
      2'b10:   result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  // Out-of-range lengths are clamped rather than rejected.
  always_comb begin
    data_len = {1'b0, DATA_LEN};
    if (DATA_LEN < 4'd5) begin
      data_len = MIN_LEN;
    end else if ({1'b0, DATA_LEN} > MAX_LEN) begin
      data_len = MAX_LEN;
    end
  end

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      len_mask[i] = (5'(i) < data_len);
    end
  end

  assign tx_fire     = Data_Valid & parity_enable;
  assign rx_fire     = RX_Valid & parity_enable;
  assign tx_parity   = parity_of(P_DATA & len_mask, PAR_TYP);
  assign rx_expected = parity_of(RX_DATA & len_mask, PAR_TYP);
  assign rx_mismatch = rx_fire & (rx_expected != RX_PAR_BIT);

  // ERR_CLR outranks a same-cycle mismatch, but the par_err pulse is still reported.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      parity_bit     <= 1'b0;
      par_valid      <= 1'b0;
      par_err        <= 1'b0;
      par_err_sticky <= 1'b0;
      err_count      <= '0;
    end else begin
      par_valid <= tx_fire;
      if (tx_fire) begin
        parity_bit <= tx_parity;
      end
      par_err <= rx_mismatch;
      if (ERR_CLR) begin
        par_err_sticky <= 1'b0;
        err_count      <= '0;
      end else if (rx_mismatch) begin
        par_err_sticky <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
